dense_seq_ctrl: RTL and testbench

Sequencer for the final dense layer of the CNN. It reads the 2704-byte feature-map RAM and the 27040-byte dense-weight RAM through their read ports and computes N_OUT dot products of length N_IN. Each score is emitted as it completes, and a done pulse follows the last one. It sits between the conv/pool stage, which fills the feature map, and the result/UART stage, which consumes the scores.

---
 rtl/dense_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_dense_seq_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_seq_ctrl.sv
// Dense-layer sequencer: streams feature-map and weight bytes through one MAC and emits N_OUT scores.
// Optional argmax tracking over the emitted scores is enabled by defining DENSE_ARGMAX_EN.
module dense_seq_ctrl #(
  parameter int N_IN  = 2704,
  parameter int N_OUT = 10,
  parameter int ACC_W = 32,
  parameter int FM_AW = 12,
  parameter int DW_AW = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    mem_lock,
  output logic [FM_AW-1:0]        fm_addr,
  input  logic [7:0]              fm_q,
  output logic [DW_AW-1:0]        dw_addr,
  input  logic [7:0]              dw_q,
  output logic                    score_valid,
  output logic [3:0]              score_idx,
  output logic signed [ACC_W-1:0] score,
  output logic                    done,
  output logic [3:0]              pred_class,
  output logic                    pred_valid
);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, EMIT, DONE} state_t;

  state_t                  state;
  logic [3:0]              o_cnt;
  logic                    drain_cnt;
  logic                    vld_p1;
  logic signed [ACC_W-1:0] acc;
  logic                    last_in;
  logic                    last_out;

  // Unsigned activation times signed weight; 17 bits hold 255 * -128 exactly.
  function automatic logic signed [ACC_W-1:0] mac_term(input logic [7:0] fm, input logic [7:0] w);
    logic signed [8:0]  a;
    logic signed [8:0]  b;
    logic signed [16:0] p;
    a = signed'({1'b0, fm});
    b = signed'({w[7], w});
    p = a * b;
    return {{(ACC_W-17){p[16]}}, p};
  endfunction

  assign mem_lock = busy;
  assign last_in  = (fm_addr == FM_AW'(N_IN - 1));
  assign last_out = (o_cnt == 4'(N_OUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      score_valid <= 1'b0;
      score       <= '0;
      score_idx   <= '0;
      fm_addr     <= '0;
      dw_addr     <= '0;
      acc         <= '0;
      o_cnt       <= '0;
      drain_cnt   <= 1'b0;
      vld_p1      <= 1'b0;
    end else begin
      score_valid <= 1'b0;
      done        <= 1'b0;
      // p0: address cycle (RUN); p1: RAM data cycle, folded into the accumulator at its end
      vld_p1      <= (state == RUN);
      if (vld_p1) acc <= acc + mac_term(fm_q, dw_q);
      case (state)
        IDLE: if (start) begin
          state   <= RUN;
          busy    <= 1'b1;
          fm_addr <= '0;
          dw_addr <= '0;
          o_cnt   <= '0;
          acc     <= '0;
        end
        RUN: if (last_in) begin
          state     <= DRAIN;
          drain_cnt <= 1'b0;
        end else begin
          fm_addr <= fm_addr + 1'b1;
          dw_addr <= dw_addr + 1'b1;
        end
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state       <= EMIT;
            score_valid <= 1'b1;
            score       <= acc;
            score_idx   <= o_cnt;
            acc         <= '0;
          end
        end
        EMIT: if (last_out) begin
          state <= DONE;
          done  <= 1'b1;
        end else begin
          state   <= RUN;
          o_cnt   <= o_cnt + 1'b1;
          fm_addr <= '0;
          dw_addr <= dw_addr + 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DENSE_ARGMAX_EN
  logic signed [ACC_W-1:0] max_val;
  logic [3:0]              max_idx;

  // Strict compare keeps the lowest index on ties; output 0 seeds the running max.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_val    <= '0;
      max_idx    <= '0;
      pred_class <= '0;
      pred_valid <= 1'b0;
    end else begin
      pred_valid <= 1'b0;
      if (state == IDLE && start) pred_class <= '0;
      if (state == DRAIN && drain_cnt && (o_cnt == 4'd0 || acc > max_val)) begin
        max_val <= acc;
        max_idx <= o_cnt;
      end
      if (state == EMIT && last_out) begin
        pred_class <= max_idx;
        pred_valid <= 1'b1;
      end
    end
  end
`else
  assign pred_class = '0;
  assign pred_valid = 1'b0;
`endif

endmodule

// File: tb/tb_dense_seq_ctrl.sv
// Bench for dense_seq_ctrl: spec-level model for the default build plus small directed instances.
module tb_dense_seq_ctrl;
  localparam int N_IN  = 2704;
  localparam int N_OUT = 10;
  localparam int P     = N_IN + 3;
`ifdef DENSE_ARGMAX_EN
  localparam bit AM = 1'b1;
`else
  localparam bit AM = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, start_s2, start_s10;
  int n_cmp = 0;
  int n_err = 0;

  // default-size DUT
  logic        busy, mem_lock, score_valid, done, pred_valid;
  logic [11:0] fm_addr;
  logic [14:0] dw_addr;
  logic [7:0]  fm_q, dw_q;
  logic [3:0]  score_idx, pred_class;
  logic signed [31:0] score;

  // N_IN=4, N_OUT=2 DUT
  logic        s2_busy, s2_lock, s2_sv, s2_done, s2_pv;
  logic [1:0]  s2_fa;
  logic [2:0]  s2_da;
  logic [7:0]  s2_fq, s2_dq;
  logic [3:0]  s2_idx, s2_pc;
  logic signed [31:0] s2_score;

  // N_IN=4, N_OUT=10 DUT
  logic        s10_busy, s10_lock, s10_sv, s10_done, s10_pv;
  logic [1:0]  s10_fa;
  logic [5:0]  s10_da;
  logic [7:0]  s10_fq, s10_dq;
  logic [3:0]  s10_idx, s10_pc;
  logic signed [31:0] s10_score;

  dense_seq_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .mem_lock(mem_lock),
    .fm_addr(fm_addr), .fm_q(fm_q), .dw_addr(dw_addr), .dw_q(dw_q),
    .score_valid(score_valid), .score_idx(score_idx), .score(score),
    .done(done), .pred_class(pred_class), .pred_valid(pred_valid));

  dense_seq_ctrl #(.N_IN(4), .N_OUT(2), .ACC_W(32), .FM_AW(2), .DW_AW(3)) u_s2 (
    .clk(clk), .rst(rst), .start(start_s2), .busy(s2_busy), .mem_lock(s2_lock),
    .fm_addr(s2_fa), .fm_q(s2_fq), .dw_addr(s2_da), .dw_q(s2_dq),
    .score_valid(s2_sv), .score_idx(s2_idx), .score(s2_score),
    .done(s2_done), .pred_class(s2_pc), .pred_valid(s2_pv));

  dense_seq_ctrl #(.N_IN(4), .N_OUT(10), .ACC_W(32), .FM_AW(2), .DW_AW(6)) u_s10 (
    .clk(clk), .rst(rst), .start(start_s10), .busy(s10_busy), .mem_lock(s10_lock),
    .fm_addr(s10_fa), .fm_q(s10_fq), .dw_addr(s10_da), .dw_q(s10_dq),
    .score_valid(s10_sv), .score_idx(s10_idx), .score(s10_score),
    .done(s10_done), .pred_class(s10_pc), .pred_valid(s10_pv));

  logic [7:0] fm_m  [N_IN];
  logic [7:0] dw_m  [N_IN*N_OUT];
  logic [7:0] fm_s  [4];
  logic [7:0] dw_s2 [8];
  logic [7:0] dw_s10[40];

  always @(posedge clk) begin
    fm_q   <= fm_m[fm_addr];
    dw_q   <= dw_m[dw_addr];
    s2_fq  <= fm_s[s2_fa];
    s2_dq  <= dw_s2[s2_da];
    s10_fq <= fm_s[s10_fa];
    s10_dq <= dw_s10[s10_da];
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain dot products and first-maximum index straight from RAM contents.
  int exp_score[N_OUT];
  int exp_pred;
  task automatic build_model();
    for (int o = 0; o < N_OUT; o++) begin
      int s;
      s = 0;
      for (int i = 0; i < N_IN; i++) begin
        int a, b;
        a = fm_m[i];
        b = $signed(dw_m[o*N_IN + i]);
        s += a * b;
      end
      exp_score[o] = s;
    end
    exp_pred = 0;
    for (int o = 1; o < N_OUT; o++) if (exp_score[o] > exp_score[exp_pred]) exp_pred = o;
  endtask

  int cyc = 0;
  int e0  = 0;
  bit m_busy = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or posedge rst) begin
    if (rst) m_busy <= 1'b0;
    else if (m_busy) begin
      if (cyc - e0 == N_OUT*P + 1) m_busy <= 1'b0;
    end else if (start) begin
      m_busy <= 1'b1;
      e0     <= cyc;
    end
  end

  int n_sv = 0, n_done = 0, first_sv_rel = -1, done_rel = -1;
  int cap_dw3 = -1, cap_fm_a = -1, cap_fm_b = -1, last_dw = -1;

  always @(negedge clk) begin
    int rel, k, ph, efm, edw;
    bit sv_e, dn_e;
    if (rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_score_valid", score_valid, 0);
      chk("rst_score", $signed(score), 0);
      chk("rst_score_idx", score_idx, 0);
      chk("rst_fm_addr", fm_addr, 0);
      chk("rst_dw_addr", dw_addr, 0);
      chk("rst_pred_class", pred_class, 0);
      chk("rst_pred_valid", pred_valid, 0);
    end else begin
      rel  = cyc - 1 - e0;
      sv_e = 1'b0;
      dn_e = 1'b0;
      if (m_busy) begin
        if (rel >= N_IN + 2 && (rel - N_IN - 2) % P == 0 && (rel - N_IN - 2) / P < N_OUT) sv_e = 1'b1;
        dn_e = (rel == N_OUT*P);
      end
      chk("busy", busy, m_busy);
      chk("mem_lock", mem_lock, m_busy);
      chk("score_valid", score_valid, sv_e);
      chk("done", done, dn_e);
      chk("pred_valid", pred_valid, AM & dn_e);
      if (dn_e) chk("pred_class", pred_class, AM ? exp_pred : 0);
      if (sv_e) begin
        k = (rel - N_IN - 2) / P;
        chk("score_idx", score_idx, k);
        chk("score", $signed(score), exp_score[k]);
      end
      if (score_valid) begin
        if (n_sv == 0 || score_idx == 0) first_sv_rel = (score_idx == 0) ? rel : first_sv_rel;
        n_sv++;
      end
      if (done) begin
        n_done++;
        done_rel = rel;
        last_dw  = dw_addr;
      end
      if (m_busy) begin
        k  = rel / P;
        ph = rel % P;
        if (k >= N_OUT) begin
          efm = N_IN - 1;
          edw = N_OUT*N_IN - 1;
        end else if (ph < N_IN) begin
          efm = ph;
          edw = k*N_IN + ph;
        end else begin
          efm = N_IN - 1;
          edw = k*N_IN + N_IN - 1;
        end
        chk("fm_addr", fm_addr, efm);
        chk("dw_addr", dw_addr, edw);
        if (rel == 3*P) cap_dw3 = dw_addr;
        if (rel == P - 1) cap_fm_a = fm_addr;
        if (rel == P) cap_fm_b = fm_addr;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int t;
    t = 0;
    while (n_done == prev && t < 30000) begin
      @(negedge clk);
      t++;
    end
    if (n_done == prev) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected one", t);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_s10(input int wv[10], output int pc, output int pv, output int nsv, output int drel);
    for (int o = 0; o < 10; o++) begin
      dw_s10[o*4] = 8'(wv[o]);
      for (int i = 1; i < 4; i++) dw_s10[o*4 + i] = 8'd0;
    end
    pc = -1; pv = -1; nsv = 0; drel = -1;
    @(negedge clk);
    start_s10 = 1'b1;
    @(negedge clk);
    start_s10 = 1'b0;
    for (int r = 1; r <= 75; r++) begin
      @(negedge clk);
      if (s10_sv) nsv++;
      if (s10_done) begin
        pc = s10_pc; pv = s10_pv; drel = r;
      end
    end
  endtask

  initial begin
    int sv_rel[2], sv_idx[2], sv_sc[2];
    int nsv, d_rel, pv_at_done, pc_at_done, busy_after;
    int pc, pv, ns, dr, base_sv, base_done;
    int wa[10], wb[10], wc[10];

    rst = 1'b0; start = 1'b0; start_s2 = 1'b0; start_s10 = 1'b0;
    #1 rst = 1'b1;
    foreach (fm_m[i]) fm_m[i] = 8'hFF;
    foreach (dw_m[i]) dw_m[i] = 8'h80;
    build_model();
    chk("model_score_ff_80", exp_score[0], -88258560);
    fm_s[0] = 8'd1; fm_s[1] = 8'd2; fm_s[2] = 8'd3; fm_s[3] = 8'd4;
    dw_s2[0] = 8'd1; dw_s2[1] = 8'd1; dw_s2[2] = 8'd1; dw_s2[3] = 8'd1;
    dw_s2[4] = 8'hFF; dw_s2[5] = 8'd0; dw_s2[6] = 8'd0; dw_s2[7] = 8'd2;
    repeat (3) @(negedge clk);
    chk("s2_rst_busy", s2_busy, 0);
    chk("s2_rst_score", $signed(s2_score), 0);
    @(posedge clk); #2 rst = 1'b0;

    // Small layer: scores 10 and 7, first at +6, done at +14; start during done is dropped.
    @(negedge clk); start_s2 = 1'b1;
    @(negedge clk); start_s2 = 1'b0;
    chk("s2_busy_accept", s2_busy, 1);
    nsv = 0; d_rel = -1; pv_at_done = -1; pc_at_done = -1; busy_after = -1;
    for (int r = 1; r <= 20; r++) begin
      @(negedge clk);
      start_s2 = 1'b0;
      if (s2_sv && nsv < 2) begin
        sv_rel[nsv] = r; sv_idx[nsv] = s2_idx; sv_sc[nsv] = s2_score;
      end
      if (s2_sv) nsv++;
      if (s2_done) begin
        d_rel = r; pv_at_done = s2_pv; pc_at_done = s2_pc;
        start_s2 = 1'b1;
      end
      if (r == 20) busy_after = s2_busy;
    end
    chk("s2_num_scores", nsv, 2);
    chk("s2_first_rel", sv_rel[0], 6);
    chk("s2_idx0", sv_idx[0], 0);
    chk("s2_score0", sv_sc[0], 10);
    chk("s2_second_rel", sv_rel[1], 13);
    chk("s2_idx1", sv_idx[1], 1);
    chk("s2_score1", sv_sc[1], 7);
    chk("s2_done_rel", d_rel, 14);
    chk("s2_pred_valid", pv_at_done, AM ? 1 : 0);
    chk("s2_pred_class", pc_at_done, 0);
    chk("s2_busy_after", busy_after, 0);
    chk("s2_dw_hold", s2_da, 7);

    // Argmax: tie at 500 keeps idx 7; equal scores give 0; all-negative max at idx 4.
    fm_s[0] = 8'd5; fm_s[1] = 8'd0; fm_s[2] = 8'd0; fm_s[3] = 8'd0;
    wa = '{10, -20, 30, 40, 50, 60, 70, 100, 100, -5};
    wb = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7};
    wc = '{-50, -50, -50, -50, -1, -50, -50, -50, -50, -50};
    run_s10(wa, pc, pv, ns, dr);
    chk("am_tie_class", pc, AM ? 7 : 0);
    chk("am_tie_valid", pv, AM ? 1 : 0);
    chk("am_tie_nsv", ns, 10);
    chk("am_tie_done_rel", dr, 70);
    run_s10(wb, pc, pv, ns, dr);
    chk("am_equal_class", pc, 0);
    run_s10(wc, pc, pv, ns, dr);
    chk("am_neg_class", pc, AM ? 4 : 0);

    // Full-size run with a redundant start mid-run.
    base_sv = n_sv; base_done = n_done;
    pulse_start();
    repeat (5000) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(base_done);
    chk("full_num_scores", n_sv - base_sv, 10);
    chk("full_num_done", n_done - base_done, 1);
    chk("full_first_rel", first_sv_rel, 2706);
    chk("full_done_rel", done_rel, 27070);
    chk("full_dw_o3_i0", cap_dw3, 8112);
    chk("full_fm_before_wrap", cap_fm_a, 2703);
    chk("full_fm_after_wrap", cap_fm_b, 0);
    chk("full_last_dw", last_dw, 27039);
    chk("full_dw_hold", dw_addr, 27039);

    // Reset while output 5 accumulates, then a fresh run on new data.
    foreach (fm_m[i]) fm_m[i] = 8'(i % 251);
    foreach (dw_m[i]) dw_m[i] = 8'((i * 37 + 11) % 256);
    build_model();
    base_done = n_done;
    pulse_start();
    repeat (5*P + 100) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done_count", n_done - base_done, 0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    base_sv = n_sv; base_done = n_done;
    pulse_start();
    wait_done(base_done);
    chk("rerun_num_scores", n_sv - base_sv, 10);
    chk("rerun_first_rel", first_sv_rel, 2706);
    chk("rerun_done_rel", done_rel, 27070);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1);
  end

endmodule
